// File: rtl/io_pad_pwr_seq_pkg.sv
// Shared types and defaults for the IO pad segment power sequencer.
package io_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_REL_RST  = 3'd2,
    ST_REL_IE   = 3'd3,
    ST_REL_OE   = 3'd4,
    ST_ON       = 3'd5,
    ST_DOWN     = 3'd6
  } io_seq_state_t;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEB_W_DEF       = 8;
  localparam int unsigned DEB_CYC_DEF     = 16;
  localparam int unsigned STEP_CYC_DEF    = 4;

  typedef struct packed {
    logic ret;
    logic ie;
    logic oe;
    logic seg_rst_n;
    logic ready;
  } pad_ctl_t;

  // All-safe pad control: retention on, buffers off, segment held in reset.
  localparam pad_ctl_t CTL_SAFE = '{ret: 1'b1, ie: 1'b0, oe: 1'b0, seg_rst_n: 1'b0, ready: 1'b0};

  // Pad control levels belonging to a state; dn_late selects the second half of DOWN.
  function automatic pad_ctl_t pad_ctl_for(io_seq_state_t st, logic dn_late);
    pad_ctl_t c;
    c = CTL_SAFE;
    case (st)
      ST_REL_RST: c.seg_rst_n = 1'b1;
      ST_REL_IE: begin
        c.seg_rst_n = 1'b1;
        c.ret       = 1'b0;
        c.ie        = 1'b1;
      end
      ST_REL_OE: begin
        c.seg_rst_n = 1'b1;
        c.ret       = 1'b0;
        c.ie        = 1'b1;
        c.oe        = 1'b1;
      end
      ST_ON: begin
        c.seg_rst_n = 1'b1;
        c.ret       = 1'b0;
        c.ie        = 1'b1;
        c.oe        = 1'b1;
        c.ready     = 1'b1;
      end
      ST_DOWN: begin
        c.seg_rst_n = 1'b1;
        c.ret       = dn_late;
        c.ie        = ~dn_late;
      end
      default: c = CTL_SAFE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/io_pad_pwr_seq_if.sv
// Pad ring control bus driven by the segment power sequencer.
interface io_pad_pwr_seq_if;
  import io_pwr_pkg::*;

  logic       pad_ret;
  logic       pad_ie;
  logic       pad_oe;
  logic       seg_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  modport master (output pad_ret, pad_ie, pad_oe, seg_rst_n, ready, fault, state);
  modport slave  (input  pad_ret, pad_ie, pad_oe, seg_rst_n, ready, fault, state);
endinterface

// File: rtl/io_pad_pwr_seq_sync.sv
// Multi-flop synchronizer for one asynchronous level, reset to 0.
module io_sync_bit
  import io_pwr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the async level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/io_pad_pwr_seq.sv
// Power-up/power-down sequencer for one IO pad segment: debounces the supply
// good flags, releases reset/IE/OE in order and drops to retention on loss.
module io_pad_pwr_seq
  import io_pwr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DEB_W       = DEB_W_DEF,
  parameter int unsigned DEB_CYC     = DEB_CYC_DEF,
  parameter int unsigned STEP_CYC    = STEP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vdd_ok_i,
  input  logic       vddio_ok_i,
  input  logic       sw_off_i,
  output logic       pad_ret_o,
  output logic       pad_ie_o,
  output logic       pad_oe_o,
  output logic       seg_rst_no,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0] STEP_LAST = DEB_W'(STEP_CYC - 1);
  localparam logic [DEB_W-1:0] CNT_MAX   = '1;

  logic          vdd_sync;
  logic          vddio_sync;
  logic          sup_ok;

  io_seq_state_t state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic          phase_q, phase_d;
  logic          fault_q, fault_d;
  pad_ctl_t      ctl_q, ctl_d;

  io_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vdd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vdd_ok_i),
    .q     (vdd_sync)
  );

  io_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vddio (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vddio_ok_i),
    .q     (vddio_sync)
  );

  assign sup_ok  = vdd_sync & vddio_sync;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DEB_W'(1);

  // Next state, step counter and the pad levels of the state being entered.
  // DOWN is split into two STEP_CYC halves by phase so the counter never has
  // to reach 2*STEP_CYC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    phase_d = phase_q;
    fault_d = fault_q;

    case (state_q)
      ST_OFF: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (sup_ok && !sw_off_i) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (cnt_q == DEB_LAST) begin
          state_d = ST_REL_RST;
          cnt_d   = '0;
        end
      end
      ST_REL_RST: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_REL_IE;
          cnt_d   = '0;
        end
      end
      ST_REL_IE: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_REL_OE;
          cnt_d   = '0;
        end
      end
      ST_REL_OE: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        cnt_d = '0;
        if (sw_off_i) begin
          state_d = ST_DOWN;
          phase_d = 1'b0;
        end
      end
      ST_DOWN: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (phase_q) state_d = ST_OFF;
          else         phase_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase

    // Supply loss overrides everything else outside OFF.
    if (state_q != ST_OFF && !sup_ok) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      phase_d = 1'b0;
      if (state_q == ST_ON) fault_d = 1'b1;
    end

    ctl_d = pad_ctl_for(state_d, phase_d);
  end

  // State, counter and registered pad control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      fault_q <= 1'b0;
      ctl_q   <= CTL_SAFE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      fault_q <= fault_d;
      ctl_q   <= ctl_d;
    end
  end

  assign pad_ret_o  = ctl_q.ret;
  assign pad_ie_o   = ctl_q.ie;
  assign pad_oe_o   = ctl_q.oe;
  assign seg_rst_no = ctl_q.seg_rst_n;
  assign ready_o    = ctl_q.ready;
  assign fault_o    = fault_q;
  assign state_o    = state_q;

endmodule

// File: doc/io_pad_pwr_seq.md
Name: io_pad_pwr_seq

Overview:
Digital power-up/power-down sequencer for one IO pad segment. The segment is protected by the HVT 0.8 V clamp cells.
- Consumes supply-good flags from the segment's analog detectors (core VDD, IO VDDIO).
- Produces ordered pad control: retention, input enable, output enable, and a segment reset.
- Pads therefore never drive while supplies ramp, and drop to safe retention immediately on supply loss.
- Sits between the analog power-good detectors and the pad ring control bus.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
DEB_W, 8, width of debounce/step counter
DEB_CYC, 16, consecutive cycles both supplies must read good before sequencing starts (1..2^DEB_W-1)
STEP_CYC, 4, cycles between successive release steps (1..2^DEB_W-1)

Ports:
clk  in  1  free-running always-on clock
rst_n  in  1  asynchronous active-low reset
vdd_ok_i  in  1  core supply good; asynchronous, from detector
vddio_ok_i  in  1  IO supply good; asynchronous, from detector
sw_off_i  in  1  synchronous software request to power the segment down
pad_ret_o  out  1  1 = pads hold state (retention)
pad_ie_o  out  1  pad input buffers enabled
pad_oe_o  out  1  pad output drivers enabled
seg_rst_no  out  1  active-low reset to segment logic
ready_o  out  1  segment fully on
fault_o  out  1  sticky: a supply was lost while in ON
state_o  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All flops reset asynchronously.
- Reset values:
  - pad_ret_o=1, pad_ie_o=0, pad_oe_o=0, seg_rst_no=0, ready_o=0, fault_o=0.
  - state=OFF, counter=0, synchronizers=0.
- Input synchronization:
  - vdd_ok_i and vddio_ok_i each pass through SYNC_STAGES flops.
  - sup_ok = AND of the synchronized values.
- FSM states, in order: OFF=0, DEBOUNCE=1, REL_RST=2, REL_IE=3, REL_OE=4, ON=5, DOWN=6.
- Transitions:
  - OFF: counter=0. Go to DEBOUNCE when sup_ok=1 and sw_off_i=0.
  - DEBOUNCE:
    - Counter increments each cycle sup_ok=1.
    - sup_ok=0 returns to OFF with counter cleared.
    - When the counter reaches DEB_CYC-1 and sup_ok=1, go to REL_RST and clear the counter.
    - Good time before REL_RST is exactly DEB_CYC cycles of synchronized sup_ok.
  - REL_RST: seg_rst_no=1. After STEP_CYC cycles go to REL_IE.
  - REL_IE: pad_ret_o=0, pad_ie_o=1. After STEP_CYC cycles go to REL_OE.
  - REL_OE: pad_oe_o=1. After STEP_CYC cycles go to ON.
  - ON: ready_o=1.
    - sw_off_i=1 goes to DOWN.
    - sup_ok=0 goes to OFF and sets fault_o.
  - DOWN: reverse order, STEP_CYC apart.
    - Cycle 0: pad_oe_o=0.
    - After STEP_CYC: pad_ie_o=0, pad_ret_o=1.
    - After 2*STEP_CYC: seg_rst_no=0, then go to OFF.
    - Counter clears on every state entry.
- Outputs are registered. Each output changes on the clock edge that enters the state that defines it.
- Supply loss in any state other than OFF:
  - Next edge forces pad_oe_o=0, pad_ie_o=0, pad_ret_o=1, seg_rst_no=0, ready_o=0, state=OFF.
  - This has priority over sw_off_i and over step timing.
- Simultaneous events:
  - sup_ok drop on the same cycle as sw_off_i: supply loss wins.
  - Counter expiry on the same cycle as a supply drop: supply loss wins.
- sw_off_i held in OFF blocks power-up. sw_off_i during the REL_* states is ignored until ON is reached.
- fault_o is sticky. It clears only on rst_n; clearing by re-sequencing is not supported.
- Invariants, checked every cycle:
  - pad_oe_o=1 implies pad_ie_o=1, seg_rst_no=1 and pad_ret_o=0.
  - pad_ret_o and pad_ie_o are never both 1.
- The counter saturates and never wraps. Step lengths are exact: STEP_CYC cycles per state.

Decomposition:
- Package io_pwr_pkg holds:
  - state enum io_seq_state_t (3 bits, encodings above);
  - default constants for DEB_CYC and STEP_CYC.
- One sub-module, io_sync_bit: a SYNC_STAGES-flop synchronizer with async active-low reset to 0. It is instantiated twice.

Test Plan:
- Reset then both ok=1 at cycle 0 (defaults):
  - seg_rst_no rises at cycle 2+16+1.
  - pad_ie_o rises, and pad_ret_o falls, 4 cycles later.
  - pad_oe_o rises 4 cycles after that.
  - ready_o rises 4 cycles after pad_oe_o.
- Glitch: vddio_ok_i low for 1 cycle at debounce count 10 -> state returns to OFF, then a full 16-cycle debounce restarts. No output changes.
- In ON, drop vdd_ok_i -> 2 synchronizer cycles later:
  - single edge sets pad_oe_o=0, pad_ie_o=0, pad_ret_o=1, seg_rst_no=0;
  - fault_o=1 and stays 1 after the supply returns and the segment re-sequences.
- In ON, pulse sw_off_i -> pad_oe_o falls next edge; pad_ie_o falls and pad_ret_o rises +4; seg_rst_no falls +8; state=OFF; fault_o=0.
- sw_off_i and a supply drop in the same cycle during DOWN -> immediate OFF with all-safe outputs on the next edge.
- Assert rst_n low mid-REL_IE -> outputs return to reset values asynchronously, without waiting for a clock edge. Random supply toggling plus assertions show the invariants never violated.
